mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer for a bit-serial core: shifts the address, checks alignment,
// then runs the memory handshake and serial data phase. Define MEM_TIMEOUT_EN for a 16-cycle ack timeout.
module mem_access_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_store,
  input  logic [2:0] func,
  input  logic       addr_bit,
  input  logic       ser_misaligned,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] bit_pos,
  output logic       ser_mode,
  output logic       ser_in_switch,
  output logic       bit_valid,
  output logic       mem_re,
  output logic       mem_we,
  output logic [3:0] mem_be
);

  // state  | meaning
  // IDLE   | waiting for start
  // ADDR   | 12 address bits shifted, low two captured
  // CHECK  | alignment verdict from the serialiser
  // READ   | mem_re held until ack
  // LDATA  | 32 load bits shifted with extension enabled
  // SDATA  | 8/16/32 store bits shifted
  // WRITE  | mem_we/mem_be held until ack
  // DONE   | one-cycle completion
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CHECK, S_READ, S_LDATA, S_SDATA, S_WRITE, S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_cnt;
  logic       r_is_store;
  logic [1:0] r_size;
  logic [1:0] r_addr_lo;
  logic [4:0] w_sdata_last;
  logic [1:0] w_size_in;
  logic       w_cnt_en;
  logic       w_timeout;

  // Signedness is applied by the serialiser, so func[2] is not needed here.
  logic       w_unused_func;
  assign w_unused_func = func[2];

  always_comb begin
    case (func[1:0])
      2'b00:   w_size_in = SZ_BYTE;
      2'b01:   w_size_in = SZ_HALF;
      default: w_size_in = SZ_WORD;
    endcase
  end

  always_comb begin
    case (r_size)
      SZ_BYTE: w_sdata_last = 5'd7;
      SZ_HALF: w_sdata_last = 5'd15;
      default: w_sdata_last = 5'd31;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [3:0] r_to;

  // Down-counter reloaded outside the handshake; reaching zero without ack ends the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to <= 4'hF;
    end else if ((r_state == S_READ || r_state == S_WRITE) && !mem_ack) begin
      r_to <= r_to - 4'd1;
    end else begin
      r_to <= 4'hF;
    end
  end

  assign w_timeout = (r_state == S_READ || r_state == S_WRITE) && !mem_ack && (r_to == 4'd0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_cnt_en = (r_state == S_ADDR) || (r_state == S_LDATA) || (r_state == S_SDATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 5'd0;
      r_is_store <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr_lo  <= 2'b00;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_is_store <= is_store;
        r_size     <= w_size_in;
      end
      if (r_state == S_ADDR && r_cnt == 5'd0) r_addr_lo[0] <= addr_bit;
      if (r_state == S_ADDR && r_cnt == 5'd1) r_addr_lo[1] <= addr_bit;
      if (w_next != r_state || !w_cnt_en) begin
        r_cnt <= 5'd0;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADDR;
      S_ADDR:  if (r_cnt == 5'd11) w_next = S_CHECK;
      S_CHECK: begin
        if (ser_misaligned)  w_next = S_IDLE;
        else if (r_is_store) w_next = S_SDATA;
        else                 w_next = S_READ;
      end
      S_READ: begin
        if (mem_ack)        w_next = S_LDATA;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_LDATA: if (r_cnt == 5'd31) w_next = S_DONE;
      S_SDATA: if (r_cnt == w_sdata_last) w_next = S_WRITE;
      S_WRITE: begin
        if (mem_ack)        w_next = S_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    fault         = 1'b0;
    bit_pos       = 5'd0;
    ser_mode      = 1'b0;
    ser_in_switch = 1'b0;
    bit_valid     = 1'b0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    case (r_state)
      S_ADDR: begin
        bit_pos   = r_cnt;
        ser_mode  = 1'b1;
        bit_valid = 1'b1;
      end
      S_CHECK: begin
        bit_pos = 5'd31;
        fault   = ser_misaligned;
      end
      S_READ: begin
        mem_re = 1'b1;
        fault  = w_timeout;
      end
      S_LDATA: begin
        bit_pos       = r_cnt;
        ser_in_switch = 1'b1;
        bit_valid     = 1'b1;
      end
      S_SDATA: begin
        bit_pos   = r_cnt;
        bit_valid = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        fault  = w_timeout;
        case (r_size)
          SZ_BYTE: mem_be = 4'b0001 << r_addr_lo;
          SZ_HALF: mem_be = r_addr_lo[1] ? 4'b1100 : 4'b0011;
          default: mem_be = 4'b1111;
        endcase
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer; offsets below are cycles after the start cycle.
module tb_mem_access_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [2:0] func = 3'b000;
  logic       addr_bit = 1'b0;
  logic       ser_misaligned = 1'b0;
  logic       mem_ack = 1'b0;
  logic       busy, done, fault, ser_mode, ser_in_switch, bit_valid, mem_re, mem_we;
  logic [4:0] bit_pos;
  logic [3:0] mem_be;

  mem_access_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .func(func),
    .addr_bit(addr_bit), .ser_misaligned(ser_misaligned), .mem_ack(mem_ack),
    .busy(busy), .done(done), .fault(fault), .bit_pos(bit_pos), .ser_mode(ser_mode),
    .ser_in_switch(ser_in_switch), .bit_valid(bit_valid), .mem_re(mem_re),
    .mem_we(mem_we), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Per-access observations gathered on the falling edge.
  logic         mon_en = 1'b0;
  int           t_base = 0;
  int           mk;
  int           probe_k = -1;
  int           done_n, done_at, fault_n, fault_at, re_n, we_n, ld_n, sd_n, both_n, be_leak;
  logic [3:0]   be_seen;
  logic [6:0]   tap12, tap13;
  logic [16:0]  probe_vec;
  logic [127:0] busy_hist;

  always @(negedge clk) begin
    if (mon_en) begin
      mk = cyc - t_base;
      if (mk >= 0 && mk < 128) busy_hist[mk] = busy;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = mk;
      end
      if (fault) begin
        fault_n++;
        if (fault_at < 0) fault_at = mk;
      end
      if (mem_re) re_n++;
      if (mem_we) begin
        we_n++;
        be_seen = mem_be;
      end else if (mem_be != 4'b0000) begin
        be_leak++;
      end
      if (mem_re && mem_we) both_n++;
      if (ser_in_switch) ld_n++;
      if (bit_valid && !ser_mode && !ser_in_switch) sd_n++;
      if (mk == 12) tap12 = {ser_mode, bit_valid, bit_pos};
      if (mk == 13) tap13 = {ser_mode, bit_valid, bit_pos};
      if (mk == probe_k)
        probe_vec = {busy, done, fault, bit_pos, ser_mode, ser_in_switch, bit_valid,
                     mem_re, mem_we, mem_be};
    end
  end

  // Called just after a rising edge; drives one access for n_cyc cycles.
  task automatic run_access(input logic st, input logic [2:0] fn, input logic [1:0] alo,
                            input logic mis, input int ack_at, input logic spur,
                            input int rst_k, input int n_cyc);
    done_n = 0; done_at = -1; fault_n = 0; fault_at = -1;
    re_n = 0; we_n = 0; ld_n = 0; sd_n = 0; both_n = 0; be_leak = 0;
    be_seen = 4'h0; tap12 = 7'h0; tap13 = 7'h0; probe_vec = 17'h1FFFF;
    busy_hist = '1;
    probe_k = (rst_k > 0) ? rst_k + 1 : -1;
    t_base = cyc;
    mon_en = 1'b1;
    start = 1'b1; is_store = st; func = fn;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk); #1;
      start          = spur && (k == 5 || k == 20);
      is_store       = ~st;
      func           = 3'b000;
      addr_bit       = (k == 1) ? alo[0] : (k == 2) ? alo[1] : 1'b1;
      ser_misaligned = (k == 13) ? mis : 1'b1;
      mem_ack        = (ack_at > 0 && k == ack_at) || (k >= 3 && k <= 6);
      rst            = (k == rst_k);
    end
    mon_en = 1'b0;
    start = 1'b0; addr_bit = 1'b0; ser_misaligned = 1'b0; mem_ack = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, fault, bit_pos, ser_mode, ser_in_switch, bit_valid,
                          mem_re, mem_we, mem_be}, 17'h0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;

    // Load word, zero-wait ack.
    run_access(1'b0, 3'b010, 2'b00, 1'b0, 14, 1'b0, 0, 50);
    chk("lw_done_at", done_at, 47);
    chk("lw_done_n", done_n, 1);
    chk("lw_fault_n", fault_n, 0);
    chk("lw_re_n", re_n, 1);
    chk("lw_we_n", we_n, 0);
    chk("lw_ldata_n", ld_n, 32);
    chk("lw_addr_end", tap12, {1'b1, 1'b1, 5'd11});
    chk("lw_check_tap", tap13, {1'b0, 1'b0, 5'd31});
    chk("lw_idle_after", busy_hist[48], 1'b0);

    // Byte store at addr_lo=10.
    run_access(1'b1, 3'b000, 2'b10, 1'b0, 22, 1'b0, 0, 26);
    chk("sb_sdata_n", sd_n, 8);
    chk("sb_we_n", we_n, 1);
    chk("sb_be", be_seen, 4'b0100);
    chk("sb_done_at", done_at, 23);
    chk("sb_re_n", re_n, 0);
    chk("sb_be_leak", be_leak, 0);

    // Half store flagged misaligned.
    run_access(1'b1, 3'b001, 2'b01, 1'b1, 0, 1'b0, 0, 16);
    chk("mis_fault_at", fault_at, 13);
    chk("mis_fault_n", fault_n, 1);
    chk("mis_mem_n", re_n + we_n, 0);
    chk("mis_done_n", done_n, 0);
    chk("mis_idle", busy_hist[14], 1'b0);

    // Load with ack 5 cycles late, spurious starts while busy.
    run_access(1'b0, 3'b100, 2'b11, 1'b0, 19, 1'b1, 0, 56);
    chk("lds_re_n", re_n, 6);
    chk("lds_done_at", done_at, 52);
    chk("lds_done_n", done_n, 1);
    chk("lds_idle", busy_hist[54], 1'b0);
    chk("lds_both", both_n, 0);

    // Half store (unsigned code) at addr_lo=10, and word store via func=111.
    run_access(1'b1, 3'b101, 2'b10, 1'b0, 30, 1'b0, 0, 34);
    chk("sh_sdata_n", sd_n, 16);
    chk("sh_be", be_seen, 4'b1100);
    chk("sh_done_at", done_at, 31);
    run_access(1'b1, 3'b111, 2'b01, 1'b0, 46, 1'b0, 0, 50);
    chk("sw_sdata_n", sd_n, 32);
    chk("sw_be", be_seen, 4'b1111);
    chk("sw_done_at", done_at, 47);

    // Reset in LDATA cycle 10 (offset 25), then a normal byte load.
    run_access(1'b0, 3'b010, 2'b00, 1'b0, 14, 1'b0, 25, 30);
    chk("rst_mid_outputs", probe_vec, 17'h0);
    chk("rst_mid_done_n", done_n, 0);
    run_access(1'b0, 3'b000, 2'b01, 1'b0, 14, 1'b0, 0, 50);
    chk("post_rst_done_at", done_at, 47);
    chk("post_rst_fault_n", fault_n, 0);

`ifdef MEM_TIMEOUT_EN
    run_access(1'b1, 3'b010, 2'b00, 1'b0, 0, 1'b0, 0, 66);
    chk("to_fault_at", fault_at, 61);
    chk("to_fault_n", fault_n, 1);
    chk("to_we_n", we_n, 16);
    chk("to_done_n", done_n, 0);
    chk("to_idle", busy_hist[62], 1'b0);
`else
    run_access(1'b1, 3'b010, 2'b00, 1'b0, 66, 1'b0, 0, 70);
    chk("wait_we_n", we_n, 21);
    chk("wait_done_at", done_at, 67);
    chk("wait_fault_n", fault_n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
